// File: rtl/kanagawa_extern_return_router.sv
// Routes each data item to the output port named by the matching entry of an index FIFO.
// Optional checks are compiled in with `define KANAGAWA_EXTERN_RETURN_ROUTER_ASSERT_EN.
module kanagawa_extern_return_router #(
    parameter int unsigned DUAL_CLOCK                 = 0,
    parameter int unsigned LOG_DEPTH                  = 5,
    parameter int unsigned INDEX_WIDTH                = 2,
    parameter int unsigned DATA_WIDTH                 = 16,
    parameter int unsigned USE_LUTRAM                 = 0,
    parameter int unsigned NUM_OUTPUT_PORTS           = 3,
    parameter int unsigned PORT_INDEX_MAP_VALUE_WIDTH = 3,
    parameter int unsigned PORT_INDEX_MAP_DEPTH       = 4,
    parameter logic [PORT_INDEX_MAP_DEPTH*PORT_INDEX_MAP_VALUE_WIDTH-1:0] PORT_INDEX_MAP = '0
) (
    input  logic                                   output_clk,
    input  logic                                   rst,
    input  logic                                   input_clk,
    input  logic                                   input_index_valid,
    output logic                                   input_index_ready,
    input  logic [INDEX_WIDTH-1:0]                 input_index_data,
    input  logic                                   input_data_valid,
    output logic                                   input_data_ready,
    input  logic [DATA_WIDTH-1:0]                  input_data_data,
    output logic [NUM_OUTPUT_PORTS-1:0]            out_valid,
    input  logic [NUM_OUTPUT_PORTS-1:0]            out_ready,
    output logic [NUM_OUTPUT_PORTS*DATA_WIDTH-1:0] out_data
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    logic [INDEX_WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH:0]     rd_bin;
    logic [INDEX_WIDTH-1:0] head;
    logic                   full;
    logic                   empty;
    logic                   wr_rst;
    logic                   push;
    logic                   pop;
    logic                   target_busy;

    assign input_index_ready = !wr_rst && !full;
    assign push              = input_index_valid && input_index_ready;
    assign head              = mem[rd_bin[LOG_DEPTH-1:0]];

    function automatic logic [LOG_DEPTH:0] bin2gray(input logic [LOG_DEPTH:0] b);
        return b ^ (b >> 1);
    endfunction

    if (DUAL_CLOCK != 0) begin : g_dual
        // Gray pointers differ in their top two bits only when the FIFO is full.
        localparam logic [LOG_DEPTH:0] FULL_MASK = (LOG_DEPTH + 1)'(3) << (LOG_DEPTH - 1);

        logic [1:0]         rst_sync;
        logic [LOG_DEPTH:0] wr_bin;
        logic [LOG_DEPTH:0] wr_gray;
        logic [LOG_DEPTH:0] rd_gray;
        logic [LOG_DEPTH:0] rd_gray_s1;
        logic [LOG_DEPTH:0] rd_gray_s2;
        logic [LOG_DEPTH:0] wr_gray_s1;
        logic [LOG_DEPTH:0] wr_gray_s2;
        logic [LOG_DEPTH:0] wr_bin_next;
        logic [LOG_DEPTH:0] rd_bin_next;

        assign wr_rst      = rst_sync[1];
        assign wr_bin_next = wr_bin + 1'b1;
        assign rd_bin_next = rd_bin + 1'b1;
        assign full        = (wr_gray ^ rd_gray_s2) == FULL_MASK;
        assign empty       = rd_gray == wr_gray_s2;

        always_ff @(posedge input_clk) begin
            rst_sync <= {rst_sync[0], rst};
        end

        always_ff @(posedge input_clk) begin
            if (wr_rst) begin
                wr_bin     <= '0;
                wr_gray    <= '0;
                rd_gray_s1 <= '0;
                rd_gray_s2 <= '0;
            end else begin
                rd_gray_s1 <= rd_gray;
                rd_gray_s2 <= rd_gray_s1;
                if (push) begin
                    wr_bin  <= wr_bin_next;
                    wr_gray <= bin2gray(wr_bin_next);
                end
            end
            if (push) mem[wr_bin[LOG_DEPTH-1:0]] <= input_index_data;
        end

        always_ff @(posedge output_clk) begin
            if (rst) begin
                rd_bin     <= '0;
                rd_gray    <= '0;
                wr_gray_s1 <= '0;
                wr_gray_s2 <= '0;
            end else begin
                wr_gray_s1 <= wr_gray;
                wr_gray_s2 <= wr_gray_s1;
                if (pop) begin
                    rd_bin  <= rd_bin_next;
                    rd_gray <= bin2gray(rd_bin_next);
                end
            end
        end
    end else begin : g_single
        logic [LOG_DEPTH:0] wr_bin;

        assign wr_rst = rst;
        assign full   = (wr_bin ^ rd_bin) == {1'b1, {LOG_DEPTH{1'b0}}};
        assign empty  = wr_bin == rd_bin;

        always_ff @(posedge output_clk) begin
            if (rst) begin
                wr_bin <= '0;
                rd_bin <= '0;
            end else begin
                if (push) wr_bin <= wr_bin + 1'b1;
                if (pop)  rd_bin <= rd_bin + 1'b1;
            end
            if (push) mem[wr_bin[LOG_DEPTH-1:0]] <= input_index_data;
        end
    end

    // Out-of-range heads match no port, so they are never busy and the data is dropped.
    always_comb begin
        target_busy = 1'b0;
        for (int unsigned p = 0; p < NUM_OUTPUT_PORTS; p++) begin
            if (32'(head) == p && out_valid[p] && !out_ready[p]) target_busy = 1'b1;
        end
    end

    assign input_data_ready = !rst && !empty && !target_busy;
    assign pop              = input_data_valid && input_data_ready;

    always_ff @(posedge output_clk) begin
        for (int unsigned p = 0; p < NUM_OUTPUT_PORTS; p++) begin
            if (rst) begin
                out_valid[p] <= 1'b0;
            end else if (pop && 32'(head) == p) begin
                out_valid[p] <= 1'b1;
            end else if (out_ready[p]) begin
                out_valid[p] <= 1'b0;
            end
            if (pop && 32'(head) == p) out_data[p*DATA_WIDTH +: DATA_WIDTH] <= input_data_data;
        end
    end

`ifdef KANAGAWA_EXTERN_RETURN_ROUTER_ASSERT_EN
    logic idx_clk;
    logic data_pend;
    logic idx_pend;

    assign idx_clk = (DUAL_CLOCK != 0) ? input_clk : output_clk;

    always_ff @(posedge output_clk) begin
        if (rst) begin
            data_pend <= 1'b0;
        end else begin
            if (pop && !(32'(head) < NUM_OUTPUT_PORTS)) $error("router: out-of-range index %0d popped", head);
            if (pop && empty) $error("router: index FIFO underflow");
            if (data_pend && !input_data_valid) $error("router: input_data_valid dropped without transfer");
            data_pend <= input_data_valid && !input_data_ready;
        end
    end

    always_ff @(posedge idx_clk) begin
        if (wr_rst) begin
            idx_pend <= 1'b0;
        end else begin
            if (push && full) $error("router: index FIFO overflow");
            if (idx_pend && !input_index_valid) $error("router: input_index_valid dropped without transfer");
            idx_pend <= input_index_valid && !input_index_ready;
        end
    end
`endif

endmodule

// File: tb/tb_kanagawa_extern_return_router.sv
// Directed and table-driven checks of the single-clock router plus a randomized dual-clock stream.
module tb_kanagawa_extern_return_router;

    localparam int unsigned N_DUAL = 10000;
    localparam int unsigned LIMIT  = 60000;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] data;
        logic [2:0]  exp_valid;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic iclk = 1'b0;
    always #5 clk = ~clk;
    always #7 iclk = ~iclk;

    // single-clock instance
    logic        rst = 1'b1;
    logic        idx_valid = 1'b0;
    logic        idx_ready;
    logic [1:0]  idx_data = '0;
    logic        dat_valid = 1'b0;
    logic        dat_ready;
    logic [15:0] dat_data = '0;
    logic [2:0]  o_valid;
    logic [2:0]  o_ready = 3'b111;
    logic [47:0] o_data;

    // dual-clock instance
    logic        d_rst = 1'b1;
    logic        d_iv = 1'b0;
    logic        d_ir;
    logic [1:0]  d_id = '0;
    logic        d_dv = 1'b0;
    logic        d_dr;
    logic [15:0] d_dd = '0;
    logic [2:0]  d_ov;
    logic [2:0]  d_ordy = 3'b000;
    logic [47:0] d_od;

    int unsigned exp_q [3][$];

    kanagawa_extern_return_router #(
        .DUAL_CLOCK(0), .LOG_DEPTH(5), .INDEX_WIDTH(2), .DATA_WIDTH(16), .NUM_OUTPUT_PORTS(3)
    ) dut (
        .output_clk(clk), .rst(rst), .input_clk(iclk),
        .input_index_valid(idx_valid), .input_index_ready(idx_ready), .input_index_data(idx_data),
        .input_data_valid(dat_valid), .input_data_ready(dat_ready), .input_data_data(dat_data),
        .out_valid(o_valid), .out_ready(o_ready), .out_data(o_data)
    );

    kanagawa_extern_return_router #(
        .DUAL_CLOCK(1), .LOG_DEPTH(5), .INDEX_WIDTH(2), .DATA_WIDTH(16), .NUM_OUTPUT_PORTS(3)
    ) dut_dual (
        .output_clk(clk), .rst(d_rst), .input_clk(iclk),
        .input_index_valid(d_iv), .input_index_ready(d_ir), .input_index_data(d_id),
        .input_data_valid(d_dv), .input_data_ready(d_dr), .input_data_data(d_dd),
        .out_valid(d_ov), .out_ready(d_ordy), .out_data(d_od)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_index(input logic [1:0] v);
        int unsigned n;
        n = 0;
        idx_valid = 1'b1;
        idx_data  = v;
        while (!idx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL index_timeout: index %0d never accepted", v);
        end
        @(posedge clk); #1;
        idx_valid = 1'b0;
    endtask

    task automatic push_data(input logic [15:0] d);
        int unsigned n;
        n = 0;
        dat_valid = 1'b1;
        dat_data  = d;
        while (!dat_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL data_timeout: data %0h never accepted", d);
        end
        @(posedge clk); #1;
        dat_valid = 1'b0;
    endtask

    task automatic run_table();
        vec_t vecs[7];
        vecs[0] = '{2'd0, 16'h0000, 3'b001};
        vecs[1] = '{2'd1, 16'h0001, 3'b010};
        vecs[2] = '{2'd2, 16'h0002, 3'b100};
        vecs[3] = '{2'd3, 16'h1234, 3'b000};
        vecs[4] = '{2'd2, 16'hFFFF, 3'b100};
        vecs[5] = '{2'd1, 16'h8000, 3'b010};
        vecs[6] = '{2'd0, 16'h5A5A, 3'b001};
        for (int v = 0; v < 7; v++) begin
            push_index(vecs[v].idx);
            push_data(vecs[v].data);
            check("vec_valid", 48'(o_valid), 48'(vecs[v].exp_valid));
            for (int p = 0; p < 3; p++)
                if (vecs[v].exp_valid[p]) check("vec_data", 48'(o_data[p*16 +: 16]), 48'(vecs[v].data));
        end
        @(posedge clk); #1;
        check("vec_drained", 48'(o_valid), 48'(0));
        check("vec_empty", 48'(dat_ready), 48'(0));
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 48'(o_valid), 48'(0));
        check("rst_idx_ready", 48'(idx_ready), 48'(0));
        check("rst_dat_ready", 48'(dat_ready), 48'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idx_ready", 48'(idx_ready), 48'(1));
        check("post_rst_dat_ready", 48'(dat_ready), 48'(0));

        // indices 0,1,2 then back-to-back data
        push_index(2'd0); push_index(2'd1); push_index(2'd2);
        check("seq_dat_ready", 48'(dat_ready), 48'(1));
        dat_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dat_data = 16'(k);
            @(posedge clk); #1;
            check("seq_valid", 48'(o_valid), 48'(3'b001 << k));
            check("seq_data", 48'(o_data[k*16 +: 16]), 48'(k));
        end
        dat_valid = 1'b0;
        @(posedge clk); #1;

        run_table();

        // head-of-line blocking on stalled port 1
        o_ready = 3'b101;
        push_index(2'd1); push_index(2'd0); push_index(2'd1);
        push_data(16'hAAAA);
        check("hol_a_valid", 48'(o_valid), 48'(3'b010));
        check("hol_a_data", 48'(o_data[31:16]), 48'(16'hAAAA));
        push_data(16'hBBBB);
        check("hol_b_valid", 48'(o_valid), 48'(3'b011));
        check("hol_b_data", 48'(o_data[15:0]), 48'(16'hBBBB));
        check("hol_a_hold", 48'(o_data[31:16]), 48'(16'hAAAA));
        dat_valid = 1'b1;
        dat_data  = 16'hCCCC;
        for (int k = 0; k < 3; k++) begin
            check("hol_blocked", 48'(dat_ready), 48'(0));
            @(posedge clk); #1;
        end
        check("hol_held_valid", 48'(o_valid), 48'(3'b010));
        check("hol_held_data", 48'(o_data[31:16]), 48'(16'hAAAA));
        o_ready = 3'b111;
        #1;
        check("hol_release", 48'(dat_ready), 48'(1));
        @(posedge clk); #1;
        dat_valid = 1'b0;
        check("hol_c_valid", 48'(o_valid), 48'(3'b010));
        check("hol_c_data", 48'(o_data[31:16]), 48'(16'hCCCC));
        @(posedge clk); #1;

        // fill the index FIFO, then free one slot
        for (int k = 0; k < 32; k++) begin
            if (k == 31) check("fill_ready_before_last", 48'(idx_ready), 48'(1));
            push_index(2'd0);
        end
        check("full_ready", 48'(idx_ready), 48'(0));
        push_data(16'h0042);
        check("unfull_ready", 48'(idx_ready), 48'(1));
        check("unfull_valid", 48'(o_valid), 48'(3'b001));
        check("unfull_data", 48'(o_data[15:0]), 48'(16'h0042));
        for (int k = 0; k < 31; k++) push_data(16'(k));
        check("drain_last_data", 48'(o_data[15:0]), 48'(30));
        check("drain_empty", 48'(dat_ready), 48'(0));
        @(posedge clk); #1;

        // reset with five items queued
        o_ready = 3'b000;
        push_index(2'd0); push_index(2'd1); push_index(2'd2); push_index(2'd0); push_index(2'd1);
        push_data(16'h0011);
        check("mid_valid", 48'(o_valid), 48'(3'b001));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 48'(o_valid), 48'(0));
        check("mid_rst_idx_ready", 48'(idx_ready), 48'(0));
        check("mid_rst_dat_ready", 48'(dat_ready), 48'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        o_ready = 3'b111;
        @(posedge clk); #1;
        check("mid_post_idx_ready", 48'(idx_ready), 48'(1));
        check("mid_post_empty", 48'(dat_ready), 48'(0));
        run_table();

        // dual-clock randomized stream
        d_rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        fork
            begin : idx_producer
                int unsigned i;
                int unsigned guard;
                logic xfer;
                i = 0; guard = 0;
                @(posedge iclk); #1;
                while (i < N_DUAL && guard < LIMIT) begin
                    if (!d_iv && $urandom_range(0, 3) != 0) begin
                        d_iv = 1'b1;
                        d_id = 2'($urandom_range(0, 2));
                    end
                    xfer = d_iv && d_ir;
                    @(posedge iclk); #1;
                    guard++;
                    if (xfer) begin
                        exp_q[d_id].push_back(i);
                        i++;
                        d_iv = 1'b0;
                    end
                end
                d_iv = 1'b0;
                if (i < N_DUAL) begin
                    checks++; errors++;
                    $display("FAIL dual_index_timeout: sent %0d of %0d", i, N_DUAL);
                end
            end
            begin : data_producer
                int unsigned i;
                int unsigned guard;
                logic xfer;
                i = 0; guard = 0;
                @(posedge clk); #2;
                while (i < N_DUAL && guard < LIMIT) begin
                    if (!d_dv && $urandom_range(0, 3) != 0) begin
                        d_dv = 1'b1;
                        d_dd = 16'(i);
                    end
                    xfer = d_dv && d_dr;
                    @(posedge clk); #2;
                    guard++;
                    if (xfer) begin
                        i++;
                        d_dv = 1'b0;
                    end
                end
                d_dv = 1'b0;
                if (i < N_DUAL) begin
                    checks++; errors++;
                    $display("FAIL dual_data_timeout: sent %0d of %0d", i, N_DUAL);
                end
            end
            begin : consumer
                int unsigned got;
                int unsigned guard;
                int unsigned e;
                logic [2:0]  cap_v;
                logic [47:0] cap_d;
                got = 0; guard = 0;
                while (got < N_DUAL && guard < LIMIT) begin
                    d_ordy = 3'($urandom_range(0, 7));
                    cap_v  = d_ov & d_ordy;
                    cap_d  = d_od;
                    @(posedge clk); #1;
                    guard++;
                    for (int p = 0; p < 3; p++) begin
                        if (cap_v[p]) begin
                            got++;
                            checks++;
                            if (exp_q[p].size() == 0) begin
                                errors++;
                                $display("FAIL dual_extra: port %0d got %0h expected nothing", p, cap_d[p*16 +: 16]);
                            end else begin
                                e = exp_q[p].pop_front();
                                if (cap_d[p*16 +: 16] != 16'(e)) begin
                                    errors++;
                                    $display("FAIL dual_order: port %0d got %0h expected %0h", p, cap_d[p*16 +: 16], 16'(e));
                                end
                            end
                        end
                    end
                end
                if (got < N_DUAL) begin
                    checks++; errors++;
                    $display("FAIL dual_recv_timeout: received %0d expected %0d", got, N_DUAL);
                end
            end
        join
        d_ordy = 3'b111;
        repeat (10) @(posedge clk);
        #1;
        check("dual_no_extra_valid", 48'(d_ov), 48'(0));
        for (int p = 0; p < 3; p++) check("dual_queue_empty", 48'(exp_q[p].size()), 48'(0));
        check("dual_fifo_empty", 48'(d_dr), 48'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
